// File: rtl/if_ctrl_if.sv
// Fetch-stage control bundle between decode/fetch logic and the if_ctrl sequencer.
// master: the controller (takes requests, drives fetch controls).
// slave: the pipeline side (issues requests, consumes fetch controls).
interface if_ctrl_if;
   logic       br8_take;
   logic       br11_take;
   logic       jr_req;
   logic       haz_ldu;
   logic       imem_ready;
   logic       halt_req;
   logic [1:0] pc_sel;
   logic       jr_sel;
   logic       pc_we;
   logic       ifid_we;
   logic       ifid_flush;
   logic       idex_bubble;
   logic       halted;

   modport master (
      input  br8_take, br11_take, jr_req, haz_ldu, imem_ready, halt_req,
      output pc_sel, jr_sel, pc_we, ifid_we, ifid_flush, idex_bubble, halted
   );

   modport slave (
      output br8_take, br11_take, jr_req, haz_ldu, imem_ready, halt_req,
      input  pc_sel, jr_sel, pc_we, ifid_we, ifid_flush, idex_bubble, halted
   );
endinterface

// File: rtl/if_ctrl.sv
// Instruction-fetch sequencing controller for the 16-bit pipeline.
// Optional statistics counters are enabled by defining IF_CTRL_STATS_EN.
module if_ctrl #(
   parameter int unsigned LDUSE_CYCLES = 1,
   parameter int unsigned JR_LAT       = 2,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
`ifdef IF_CTRL_STATS_EN
   output logic [CNT_W-1:0] stat_stall,
   output logic [CNT_W-1:0] stat_flush,
   output logic [CNT_W-1:0] stat_redirect,
`endif
   if_ctrl_if.master        bus
);

   typedef enum logic [2:0] {StRun, StLdStall, StJrWait, StMemWait, StHalt} state_e;

   // Pending redirect uses the pc_sel encoding: 0 none, 1 jmp8, 2 jmp11.
   // A register jump is never parked; it always goes straight to JRWAIT.
   state_e     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [1:0] pend_q, pend_d;
   logic [1:0] req_sel;
   logic [1:0] eff_sel;
   logic       jr_v;

   // Decode redirect requests; ignored while a load-use hazard is flagged
   always_comb begin
      req_sel = 2'd0;
      if (!bus.haz_ldu) begin
         if (bus.br11_take) begin
            req_sel = 2'd2;
         end else if (bus.br8_take) begin
            req_sel = 2'd1;
         end
      end
      jr_v    = bus.jr_req && !bus.haz_ldu;
      eff_sel = (req_sel > pend_q) ? req_sel : pend_q;
   end

   // State, counter and pending-redirect registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StRun;
         cnt_q   <= 3'd0;
         pend_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
      end
   end

   // Next-state and combinational fetch controls
   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      pend_d          = pend_q;
      bus.pc_sel      = 2'd0;
      bus.jr_sel      = 1'b0;
      bus.pc_we       = 1'b0;
      bus.ifid_we     = 1'b0;
      bus.ifid_flush  = 1'b0;
      bus.idex_bubble = 1'b0;
      bus.halted      = 1'b0;

      unique case (state_q)
         StRun: begin
            if (bus.halt_req) begin
               bus.ifid_flush = 1'b1;
               state_d        = StHalt;
            end else if (bus.haz_ldu) begin
               bus.idex_bubble = 1'b1;
               cnt_d           = 3'(LDUSE_CYCLES - 1);
               state_d         = (LDUSE_CYCLES == 1) ? StRun : StLdStall;
            end else if (jr_v) begin
               bus.ifid_flush = 1'b1;
               cnt_d          = 3'(JR_LAT - 1);
               state_d        = StJrWait;
            end else if (req_sel != 2'd0) begin
               bus.ifid_flush = 1'b1;
               if (bus.imem_ready) begin
                  bus.pc_sel = req_sel;
                  bus.pc_we  = 1'b1;
               end else begin
                  pend_d  = req_sel;
                  state_d = StMemWait;
               end
            end else if (bus.imem_ready) begin
               bus.pc_we   = 1'b1;
               bus.ifid_we = 1'b1;
            end else begin
               bus.ifid_flush = 1'b1;
               pend_d         = 2'd0;
               state_d        = StMemWait;
            end
         end

         StLdStall: begin
            bus.idex_bubble = 1'b1;
            cnt_d           = cnt_q - 3'd1;
            if (cnt_q <= 3'd1) begin
               state_d = StRun;
            end
            if (bus.halt_req) begin
               state_d = StHalt;
            end
         end

         StJrWait: begin
            bus.ifid_flush = 1'b1;
            if (cnt_q == 3'd0) begin
               bus.jr_sel = 1'b1;
               bus.pc_we  = 1'b1;
               state_d    = StRun;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
            if (bus.halt_req) begin
               state_d = StHalt;
            end
         end

         StMemWait: begin
            if (jr_v) begin
               // jmpr does not depend on imem, so resolve it without waiting
               bus.ifid_flush = 1'b1;
               pend_d         = 2'd0;
               cnt_d          = 3'(JR_LAT - 1);
               state_d        = StJrWait;
            end else if (!bus.imem_ready) begin
               bus.ifid_flush = 1'b1;
               pend_d         = eff_sel;
            end else if (eff_sel != 2'd0) begin
               bus.pc_sel     = eff_sel;
               bus.pc_we      = 1'b1;
               bus.ifid_flush = 1'b1;
               pend_d         = 2'd0;
               state_d        = StRun;
            end else begin
               bus.pc_we   = 1'b1;
               bus.ifid_we = 1'b1;
               state_d     = StRun;
            end
            if (bus.halt_req) begin
               state_d = StHalt;
            end
         end

         StHalt: begin
            bus.ifid_flush = 1'b1;
            bus.halted     = 1'b1;
         end

         default: begin
            state_d = StRun;
         end
      endcase

      // Reset holds the front end quiet with bubbles in both stage registers
      if (rst) begin
         bus.pc_sel      = 2'd0;
         bus.jr_sel      = 1'b0;
         bus.pc_we       = 1'b0;
         bus.ifid_we     = 1'b0;
         bus.ifid_flush  = 1'b1;
         bus.idex_bubble = 1'b1;
         bus.halted      = 1'b0;
      end
   end

`ifdef IF_CTRL_STATS_EN
   localparam logic [CNT_W-1:0] CntMax = '1;

   logic not_halt;
   logic redirect_applied;

   assign not_halt         = (state_q != StHalt);
   assign redirect_applied = bus.pc_we && ((bus.pc_sel != 2'd0) || bus.jr_sel);

   // Saturating statistics counters
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_stall    <= '0;
         stat_flush    <= '0;
         stat_redirect <= '0;
      end else begin
         if (not_halt && !bus.pc_we && (stat_stall != CntMax)) begin
            stat_stall <= stat_stall + 1'b1;
         end
         if (not_halt && bus.ifid_flush && (stat_flush != CntMax)) begin
            stat_flush <= stat_flush + 1'b1;
         end
         if (redirect_applied && (stat_redirect != CntMax)) begin
            stat_redirect <= stat_redirect + 1'b1;
         end
      end
   end
`endif

endmodule

// File: doc/if_ctrl.md
Name: if_ctrl

Overview:
- Sequencing controller for the instruction-fetch stage of the 16-bit pipeline.
- Drives the fetch-stage PC-difference select (pc_sel) and register-jump select (jr_sel), the PC write enable, and IF/ID stall and flush.
- Inputs: redirect requests from decode, load-use hazards, instruction-memory readiness and halt.
- Holds pending redirects across memory wait states and times multi-cycle register-jump resolution.

Parameters:
- LDUSE_CYCLES, 1, stall cycles inserted per load-use hazard (1..7).
- JR_LAT, 2, cycles from jr request until jmpr target is valid (1..7).
- CNT_W, 16, width of optional statistics counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- br8_take  in  1  decode: taken short branch, target via jmp8.
- br11_take  in  1  decode: taken long jump, target via jmp11.
- jr_req  in  1  decode: register jump, target via jmpr.
- haz_ldu  in  1  decode: load-use hazard on instruction in ID.
- imem_ready  in  1  instruction memory returns valid data this cycle.
- halt_req  in  1  halt fetch; sticky until reset.
- pc_sel  out  2  0 = +1, 1 = jmp8, 2 = jmp11; 3 never driven.
- jr_sel  out  1  1 = load PC from jmpr.
- pc_we  out  1  PC register update enable.
- ifid_we  out  1  IF/ID register write enable.
- ifid_flush  out  1  load a bubble into IF/ID.
- idex_bubble  out  1  insert a bubble into ID/EX.
- halted  out  1  controller is in HALT.

Behaviour:
- State register values: RUN, LDSTALL, JRWAIT, MEMWAIT, HALT.
- Outputs are combinational from state and inputs; state, counters and pending registers are registered.
- Reset (rst=1 at an edge): state=RUN, counters=0, pending=none.
- While rst=1, outputs are forced: pc_sel=0, jr_sel=0, pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, halted=0.
- Reset mid-operation discards any pending redirect, stall or wait.
- Redirect requests are considered only while haz_ldu=0.
- Redirect priority: jr_req > br11_take > br8_take.
- RUN, priority order:
  - halt_req: ifid_flush=1, pc_we=0; next state HALT.
  - haz_ldu: pc_we=0, ifid_we=0, idex_bubble=1; counter=LDUSE_CYCLES-1; next state RUN if LDUSE_CYCLES=1, else LDSTALL. Any branch inputs this cycle are ignored; decode re-presents them.
  - jr_req: pc_we=0, ifid_flush=1; counter=JR_LAT-1; next state JRWAIT.
  - br11/br8 with imem_ready=1: pc_sel=2 or 1, pc_we=1, ifid_flush=1 (squash the sequential fetch); stay in RUN.
  - Any redirect with imem_ready=0: latch the redirect into pending; pc_we=0, ifid_flush=1; next state MEMWAIT.
  - No event, imem_ready=1: pc_sel=0, pc_we=1, ifid_we=1.
  - No event, imem_ready=0: pc_we=0, ifid_flush=1; next state MEMWAIT with no pending redirect.
- LDSTALL: pc_we=0, ifid_we=0, idex_bubble=1; counter decrements; when counter=0 next state RUN. halt_req sends the next state to HALT.
- JRWAIT: pc_we=0, ifid_flush=1; counter decrements.
  - When counter=0: jr_sel=1, pc_we=1, next state RUN.
  - JR_LAT=1 resolves on the first JRWAIT cycle.
  - The jmpr redirect is not gated by imem_ready.
- MEMWAIT: pc_we=0, ifid_flush=1 while imem_ready=0.
  - On imem_ready=1 with a pending redirect: apply it exactly once (pc_sel per pending, pc_we=1, ifid_flush=1), clear pending, next state RUN.
  - On imem_ready=1 without a pending redirect: normal +1 fetch with ifid_we=1.
  - New redirects arriving in MEMWAIT overwrite pending by priority; a pending jr enters JRWAIT instead.
- HALT: pc_we=0, ifid_we=0, ifid_flush=1, halted=1; left only by reset.
- Invariants:
  - ifid_we and ifid_flush are never both 1.
  - jr_sel=1 implies pc_sel=0.
  - pc_we=1 at most once per accepted redirect.

Optional Feature:
- Macro: IF_CTRL_STATS_EN.
- When defined, adds output ports:
  - stat_stall [CNT_W-1:0]: counts cycles with pc_we=0 outside HALT.
  - stat_flush [CNT_W-1:0]: counts cycles with ifid_flush=1 outside HALT and reset.
  - stat_redirect [CNT_W-1:0]: counts applied redirects.
- Counters saturate at all-ones, clear on rst, and count only while rst=0.
- When undefined: these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Reset held 3 cycles, then imem_ready=1 and no events → first cycle after reset: pc_we=1, pc_sel=0, ifid_we=1, halted=0.
- RUN, br8_take=1 for one cycle with imem_ready=1 → that cycle: pc_sel=1, pc_we=1, ifid_flush=1; next cycle back to pc_sel=0, ifid_we=1.
- jr_req=1 with JR_LAT=2 → cycle 0: pc_we=0, flush=1; cycle 1: flush=1; cycle 2: jr_sel=1, pc_we=1; cycle 3: normal fetch.
- br11_take=1 while imem_ready=0, imem_ready low 3 more cycles → pc_we=0 for 4 cycles; at ready: pc_sel=2, pc_we=1 exactly once.
- haz_ldu=1 together with br8_take=1, LDUSE_CYCLES=2 → 2 cycles of pc_we=0, ifid_we=0, idex_bubble=1; branch not applied; re-presented br8 then applies with pc_sel=1.
- halt_req in JRWAIT, then rst pulse mid-HALT → halted=1 from the cycle after the request; after rst: state RUN, no pending redirect, no jr_sel pulse. With IF_CTRL_STATS_EN: all stat_* = 0 after rst.
